param_updown_counter: RTL

- Parametrised successor to the team's 4-bit binary up/down counter with load and count enable.
- Adds configurable width, programmable modulus, variable step, and wrap or saturate mode at the bound.
- Adds a terminal-count flag, a registered wrap/limit pulse, and a sticky overflow flag.
- Used as the general counting element in lab datapaths: timers, decade counters, address generators.

---
 rtl/param_updown_counter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: programmable modulus, variable step, wrap or saturate
// at the bound, combinational terminal count, registered wrap pulse and sticky overflow.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             count,
    input  logic             updown,
    input  logic [WIDTH-1:0] step,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] A_count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             ovf_reg, ovf_next;
    logic [WIDTH-1:0] arith_val;
    logic             arith_wrap;
    logic [WIDTH:0]   cur_w, step_w;

    // One extra bit so the sum and the bound comparison cannot overflow.
    assign cur_w  = {1'b0, count_reg};
    assign step_w = {1'b0, step};

    generate
        if (SATURATE) begin : g_sat
            logic [WIDTH:0] sum_w;
            always_comb begin
                sum_w      = cur_w + step_w;
                arith_val  = count_reg;
                arith_wrap = 1'b0;
                if (!updown) begin
                    if (sum_w > MAX_W) begin
                        arith_val  = MAX_N;
                        arith_wrap = 1'b1;
                    end else begin
                        arith_val = WIDTH'(sum_w);
                    end
                end else begin
                    if (step_w > cur_w) begin
                        arith_val  = '0;
                        arith_wrap = 1'b1;
                    end else begin
                        arith_val = WIDTH'(cur_w - step_w);
                    end
                end
            end
        end else begin : g_wrap
            localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MAX_VAL + 1);
            logic [WIDTH:0] step_mod, sum_w, diff_w;
            always_comb begin
                // Reduce the step first so a single subtract/add brings the result back in range.
                step_mod   = step_w % MOD_W;
                sum_w      = cur_w + step_mod;
                diff_w     = cur_w + MOD_W - step_mod;
                arith_val  = count_reg;
                arith_wrap = 1'b0;
                if (!updown) begin
                    if (sum_w > MAX_W) begin
                        arith_val  = WIDTH'(sum_w - MOD_W);
                        arith_wrap = 1'b1;
                    end else begin
                        arith_val = WIDTH'(sum_w);
                    end
                end else begin
                    if (step_mod > cur_w) begin
                        arith_val  = WIDTH'(diff_w);
                        arith_wrap = 1'b1;
                    end else begin
                        arith_val = WIDTH'(cur_w - step_mod);
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = (data_in > MAX_N) ? MAX_N : data_in;
        end else if (count && (step != '0)) begin
            count_next = arith_val;
            wrap_next  = arith_wrap;
        end
        // A crossing on the same edge beats a clear request.
        ovf_next = ovf_reg;
        if (wrap_next) begin
            ovf_next = 1'b1;
        end else if (flag_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign A_count    = count_reg;
    assign wrap_pulse = wrap_reg;
    assign ovf_sticky = ovf_reg;
    assign tc = count & ~load & ((~updown & (count_reg == MAX_N)) | (updown & (count_reg == '0)));

endmodule
